// File: rtl/jtag_arb_pkg.sv
// Shared types and constants for the JTAG UART TX arbiter.
// The optional header byte (JTAG_ARB_HDR_EN) uses HDR_TAG in its upper nibble.
package jtag_arb_pkg;

  // Arbiter states. ST_HDR is only entered when JTAG_ARB_HDR_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Upper nibble of the per-grant header byte
  localparam logic [3:0] HDR_TAG = 4'hA;

  // Header byte announcing which requester owns the following payload
  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/jtag_rr_picker.sv
// Round-robin pick for the JTAG TX arbiter.
// Purely combinational: returns the first valid requester index at or after
// rr_ptr, wrapping modulo N_REQ, plus a flag saying whether any is valid.
module jtag_rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   rr_ptr,
  output logic             any,
  output logic [IDW-1:0]   pick
);

  // One spare bit so rr_ptr + offset never overflows before the wrap
  localparam int SW = IDW + 1;

  logic [SW-1:0] cand;

  // Walk offsets from far to near so the nearest valid index wins last
  always_comb begin
    any  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + SW'(k);
      if (cand >= SW'(N_REQ)) begin
        cand = cand - SW'(N_REQ);
      end
      if (req_valid[cand[IDW-1:0]]) begin
        any  = 1'b1;
        pick = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/jtag_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the JTAG UART adapter TX byte
// stream among N_REQ byte-stream requesters. A grant is held from the first
// beat until the requester's last byte, a length cap, or an idle watchdog.
// Optional feature: define JTAG_ARB_HDR_EN to prefix every grant with one
// header byte {HDR_TAG, grant_id}.
module jtag_tx_arbiter
  import jtag_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int MAX_PKT_LEN = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_REQ*8-1:0]                      req_data,
  input  logic [N_REQ-1:0]                        req_valid,
  input  logic [N_REQ-1:0]                        req_last,
  output logic [N_REQ-1:0]                        req_ready,
  output logic [7:0]                              tx_data,
  output logic                                    tx_valid,
  input  logic                                    tx_ready,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                                    busy,
  output logic                                    timeout_err
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BCW = $clog2(MAX_PKT_LEN) + 1;
  localparam int ICW = $clog2(TIMEOUT_CYC) + 1;

  // Terminal counts, compared against the counter value before it advances
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_PKT_LEN - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [BCW-1:0]   beat_cnt;
  logic [ICW-1:0]   idle_cnt;

  logic             req_any;
  logic [IDW-1:0]   req_pick;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             beat;
  logic [IDW-1:0]   next_ptr;

  jtag_rr_picker #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (req_any),
    .pick      (req_pick)
  );

  // Signals of the currently granted requester
  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[{grant_id, 3'b000} +: 8];

  // Pointer to the requester after the current grant, wrapping at N_REQ
  assign next_ptr = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // Drive the adapter from the granted requester (or the header byte)
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state)
      ST_LOCK: begin
        tx_valid            = sel_valid;
        tx_data             = sel_data;
        req_ready[grant_id] = tx_ready;
      end
`ifdef JTAG_ARB_HDR_EN
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte(4'(grant_id));
      end
`endif
      default: begin
      end
    endcase
  end

  assign beat = tx_valid & tx_ready;

  // Arbitration FSM with beat counter, idle watchdog and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            grant_id <= req_pick;
            busy     <= 1'b1;
            beat_cnt <= '0;
            idle_cnt <= '0;
`ifdef JTAG_ARB_HDR_EN
            state    <= ST_HDR;
`else
            state    <= ST_LOCK;
`endif
          end
        end
`ifdef JTAG_ARB_HDR_EN
        ST_HDR: begin
          // Header is always valid, so tx_ready alone completes its beat
          if (tx_ready) begin
            state <= ST_LOCK;
          end
        end
`endif
        ST_LOCK: begin
          if (beat) begin
            if (beat_cnt != '1) begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
            idle_cnt <= '0;
            if (sel_last || (beat_cnt == BEAT_LAST)) begin
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= ST_IDLE;
              // A cap release splits the packet; flag it unless it ended anyway
              if (!sel_last) begin
                timeout_err <= 1'b1;
              end
            end
          end else if (!sel_valid) begin
            // Backpressure with data waiting is legal; only a silent
            // requester advances the watchdog
            if (idle_cnt == IDLE_LAST) begin
              busy        <= 1'b0;
              rr_ptr      <= next_ptr;
              state       <= ST_IDLE;
              timeout_err <= 1'b1;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + ICW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tx_arbiter.sv
// Self-checking bench for jtag_tx_arbiter (N_REQ=2, short cap and watchdog).
// Requesters are modelled as byte queues; expected beats go to a scoreboard
// queue and are popped by a monitor when the adapter side accepts a byte.
// Works with and without JTAG_ARB_HDR_EN.
module tb_jtag_tx_arbiter;
  import jtag_arb_pkg::*;

  localparam int N_REQ       = 2;
  localparam int MAX_PKT_LEN = 5;
  localparam int TIMEOUT_CYC = 16;
`ifdef JTAG_ARB_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] req_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [0:0]       grant_id;
  logic             busy;
  logic             timeout_err;

  jtag_tx_arbiter #(
    .N_REQ       (N_REQ),
    .MAX_PKT_LEN (MAX_PKT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rbyte_t;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       last;
    logic       mark;
  } exp_t;

  typedef struct {
    int         req;
    logic [7:0] data;
    bit         last;
    int         exp_id;
    logic [7:0] exp_data;
    bit         exp_last;
    bit         exp_first;
  } vec_t;

  rbyte_t     rq0[$];
  rbyte_t     rq1[$];
  exp_t       expq[$];
  int         beat_cyc[$];
  bit         beat_last[$];
  exp_t       mon_e;
  logic [1:0] acc;
  bit         tx_toggle = 1'b0;
  int         mark_cyc = -1;
  int         to_cnt = 0;
  int         to_cyc = -1;
  int         ncmp = 0;
  int         nerr = 0;
  vec_t       vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: records acceptances, watchdog pulses and scores every beat
  always @(negedge clk) begin
    acc = '0;
    if (rst_n) begin
      acc = req_valid & req_ready;
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (tx_valid && tx_ready) begin
        if (expq.size() == 0) begin
          ncmp++;
          nerr++;
          $display("[TB] FAIL unexpected_beat: got data 0x%02h id %0d, expected no beat", tx_data, grant_id);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("beat_id", {31'b0, grant_id}, {31'b0, mon_e.id});
          checkOutput("beat_data", {24'b0, tx_data}, {24'b0, mon_e.data});
          beat_cyc.push_back(cyc);
          beat_last.push_back(mon_e.last);
          if (mon_e.mark) mark_cyc = cyc;
        end
      end
    end
  end

  // Requester and adapter driver, updated just after each rising edge
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (acc[0] && rq0.size() > 0) rq0.delete(0);
      if (acc[1] && rq1.size() > 0) rq1.delete(0);
      tx_ready = tx_toggle ? ~tx_ready : 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      if (rq0.size() > 0) begin
        req_valid[0]    = 1'b1;
        req_last[0]     = rq0[0].last;
        req_data[7:0]   = rq0[0].data;
      end
      if (rq1.size() > 0) begin
        req_valid[1]    = 1'b1;
        req_last[1]     = rq1[0].last;
        req_data[15:8]  = rq1[0].data;
      end
    end
  end

  task automatic pushExp(input int id, input logic [7:0] data, input bit last, input bit first, input bit mark);
    exp_t e;
    if (first && HDR_EN) begin
      e.id   = id[0];
      e.data = {HDR_TAG, 4'(id)};
      e.last = 1'b0;
      e.mark = 1'b0;
      expq.push_back(e);
    end
    e.id   = id[0];
    e.data = data;
    e.last = last;
    e.mark = mark;
    expq.push_back(e);
  endtask

  task automatic pushReq(input int req, input logic [7:0] data, input bit last);
    rbyte_t b;
    b.data = data;
    b.last = last;
    if (req == 0) rq0.push_back(b);
    else rq1.push_back(b);
  endtask

  task automatic applyStimulus(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      pushReq(vecs[k].req, vecs[k].data, vecs[k].last);
      pushExp(vecs[k].exp_id, vecs[k].exp_data, vecs[k].exp_last, vecs[k].exp_first, 1'b0);
    end
  endtask

  task automatic flushAll();
    rq0.delete();
    rq1.delete();
    expq.delete();
  endtask

  task automatic waitDrain(input string name, input int max_cyc);
    int n = 0;
    while ((expq.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_drained"}, {31'b0, (expq.size() == 0 && rq0.size() == 0 && rq1.size() == 0)}, 32'd1);
    flushAll();
  endtask

  task automatic waitExpEmpty(input string name, input int max_cyc);
    int n = 0;
    while (expq.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_exp_empty"}, {31'b0, (expq.size() == 0)}, 32'd1);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    flushAll();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    beat_cyc.delete();
    beat_last.delete();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int to0;
    int nb;

    // Rows 0..2: single req0 packet; rows 3..10: req0/req1 two 2-byte packets each
    vecs[0]  = '{0, 8'h11, 1'b0, 0, 8'h11, 1'b0, 1'b1};
    vecs[1]  = '{0, 8'h22, 1'b0, 0, 8'h22, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'h33, 1'b1, 0, 8'h33, 1'b1, 1'b0};
    vecs[3]  = '{0, 8'hA0, 1'b0, 0, 8'hA0, 1'b0, 1'b1};
    vecs[4]  = '{0, 8'hA1, 1'b1, 0, 8'hA1, 1'b1, 1'b0};
    vecs[5]  = '{1, 8'hB0, 1'b0, 1, 8'hB0, 1'b0, 1'b1};
    vecs[6]  = '{1, 8'hB1, 1'b1, 1, 8'hB1, 1'b1, 1'b0};
    vecs[7]  = '{0, 8'hA2, 1'b0, 0, 8'hA2, 1'b0, 1'b1};
    vecs[8]  = '{0, 8'hA3, 1'b1, 0, 8'hA3, 1'b1, 1'b0};
    vecs[9]  = '{1, 8'hB2, 1'b0, 1, 8'hB2, 1'b0, 1'b1};
    vecs[10] = '{1, 8'hB3, 1'b1, 1, 8'hB3, 1'b1, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("rst_req_ready", {30'b0, req_ready}, 32'd0);
    checkOutput("rst_grant_id", {31'b0, grant_id}, 32'd0);
    checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Single 3-byte packet from req0; busy falls the cycle after the last beat
    $display("[TB] single packet");
    applyStimulus(0, 3);
    waitExpEmpty("t1", 50);
    checkOutput("t1_busy_at_last", {31'b0, busy}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("t1_busy_after_last", {31'b0, busy}, 32'd0);
    waitDrain("t1", 20);

    // Both requesters valid from reset: strict alternation, one idle gap
    $display("[TB] round robin");
    resetDut();
    applyStimulus(3, 11);
    waitDrain("t2", 100);
    nb = 8 + (HDR_EN ? 4 : 0);
    checkOutput("t2_beat_count", beat_cyc.size(), nb);
    for (int i = 1; i < beat_cyc.size(); i++) begin
      checkOutput("t2_beat_spacing", beat_cyc[i] - beat_cyc[i-1], beat_last[i-1] ? 2 : 1);
    end

    // req1 4-byte packet under toggling backpressure
    $display("[TB] backpressure");
    to0 = to_cnt;
    tx_toggle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pushReq(1, 8'hC1 + 8'(i), i == 3);
      pushExp(1, 8'hC1 + 8'(i), i == 3, i == 0, 1'b0);
    end
    waitDrain("t3", 100);
    tx_toggle = 1'b0;
    checkOutput("t3_no_timeout", to_cnt - to0, 0);

    // req0 goes silent mid-packet; watchdog releases and req1 is served
    $display("[TB] watchdog");
    to0 = to_cnt;
    mark_cyc = -1;
    pushReq(0, 8'hF0, 1'b0);
    pushReq(1, 8'h60, 1'b1);
    pushExp(0, 8'hF0, 1'b0, 1'b1, 1'b1);
    pushExp(1, 8'h60, 1'b1, 1'b1, 1'b0);
    waitDrain("t4", TIMEOUT_CYC + 40);
    checkOutput("t4_timeout_pulses", to_cnt - to0, 1);
    checkOutput("t4_timeout_delay", to_cyc - mark_cyc, TIMEOUT_CYC + 1);

    // Length cap splits req0's 7-byte packet; req1 slips in between
    $display("[TB] length cap");
    to0 = to_cnt;
    mark_cyc = -1;
    for (int i = 0; i < 7; i++) pushReq(0, 8'h70 + 8'(i), i == 6);
    pushReq(1, 8'hD0, 1'b1);
    for (int i = 0; i < 5; i++) pushExp(0, 8'h70 + 8'(i), i == 4, i == 0, i == 4);
    pushExp(1, 8'hD0, 1'b1, 1'b1, 1'b0);
    pushExp(0, 8'h75, 1'b0, 1'b1, 1'b0);
    pushExp(0, 8'h76, 1'b1, 1'b0, 1'b0);
    waitDrain("t5", 100);
    checkOutput("t5_timeout_pulses", to_cnt - to0, 1);
    checkOutput("t5_timeout_delay", to_cyc - mark_cyc, 1);

    // Reset in the middle of a req1 packet, then a fresh req1 grant
    $display("[TB] reset mid-packet");
    resetDut();
    for (int i = 0; i < 4; i++) pushReq(1, 8'h61 + 8'(i), i == 3);
    pushExp(1, 8'h61, 1'b0, 1'b1, 1'b0);
    pushExp(1, 8'h62, 1'b0, 1'b0, 1'b0);
    waitExpEmpty("t6", 50);
    @(posedge clk);
    #3;
    checkOutput("t6_busy_before", {31'b0, busy}, 32'd1);
    checkOutput("t6_grant_before", {31'b0, grant_id}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_busy_rst", {31'b0, busy}, 32'd0);
    checkOutput("t6_tx_valid_rst", {31'b0, tx_valid}, 32'd0);
    checkOutput("t6_req_ready_rst", {30'b0, req_ready}, 32'd0);
    checkOutput("t6_grant_rst", {31'b0, grant_id}, 32'd0);
    checkOutput("t6_timeout_rst", {31'b0, timeout_err}, 32'd0);
    flushAll();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    pushReq(1, 8'h5E, 1'b1);
    pushExp(1, 8'h5E, 1'b1, 1'b1, 1'b0);
    waitDrain("t6", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
